// File: rtl/ram_multi_read_port.sv
//-----------------------------------------------------------------------------
// ram_multi_read_port
//
// Register-file RAM with one synchronous write port and NUM_READ synchronous
// read ports. Each read port has a registered data output and a valid flag.
// A clear sequencer zeroes every word after reset and whenever iClear is
// pulsed while the array is READY. The array is inaccessible while the sweep
// runs.
//
// Parameters
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  address width of every port
//   MEM_SIZE    number of words; legal addresses are 0..MEM_SIZE-1
//   NUM_READ    number of read ports (1..8)
//   BYPASS      read-during-write: 0 = old word, 1 = word being written
//
// Ports
//   Clock          rising-edge clock for all state
//   Reset          asynchronous active-low reset
//   iClear         one-cycle pulse; restarts the clear sweep (READY only)
//   iWriteEnable   write strobe
//   iWriteAddress  write address
//   iDataIn        write data
//   iReadEnable    per-port read strobe, bit k is port k
//   iReadAddress   packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   oDataOut       packed registered read data, same packing
//   oReadValid     per-port flag: slice k was updated by the last edge
//   oReady         high while the array is accessible
//-----------------------------------------------------------------------------
module ram_multi_read_port #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 256,
    parameter int NUM_READ   = 4,
    parameter int BYPASS     = 0
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           iClear,
    input  logic                           iWriteEnable,
    input  logic [ADDR_WIDTH-1:0]          iWriteAddress,
    input  logic [DATA_WIDTH-1:0]          iDataIn,
    input  logic [NUM_READ-1:0]            iReadEnable,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] iReadAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0] oDataOut,
    output logic [NUM_READ-1:0]            oReadValid,
    output logic                           oReady
);

    // Index width of the storage array. The address ports may be wider than
    // this; the upper address bits only take part in the range check.
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    //-------------------------------------------------------------------------
    // Elaboration-time parameter legality.
    //-------------------------------------------------------------------------
    if (MEM_SIZE < 1 || MEM_SIZE > (2 ** ADDR_WIDTH)) begin : g_bad_mem_size
        $error("ram_multi_read_port: MEM_SIZE must be in 1..2**ADDR_WIDTH");
    end
    if (NUM_READ < 1 || NUM_READ > 8) begin : g_bad_num_read
        $error("ram_multi_read_port: NUM_READ must be in 1..8");
    end
    if (BYPASS != 0 && BYPASS != 1) begin : g_bad_bypass
        $error("ram_multi_read_port: BYPASS must be 0 or 1");
    end

    //-------------------------------------------------------------------------
    // Declarations
    //-------------------------------------------------------------------------
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       sweep_cnt;
    logic                   sweep_last;
    logic                   accessible;

    logic                   wr_in_range;
    logic                   user_write;
    logic                   mem_we;
    logic [IDX_W-1:0]       mem_widx;
    logic [DATA_WIDTH-1:0]  mem_wdata;

    logic [DATA_WIDTH-1:0]  mem [MEM_SIZE];

    //-------------------------------------------------------------------------
    // FSM: state register
    //-------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so that all
    // registers sample the values from before the edge, whatever the order
    // in which the simulator runs the blocks.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: next-state logic
    //-------------------------------------------------------------------------
    // NOTE: each combinational block assigns a default to every signal it
    // drives before any branch, so no path can leave a value unassigned and
    // infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            CLEAR: if (sweep_last) state_next = READY;
            READY: if (iClear)     state_next = CLEAR;
            default:               state_next = CLEAR;
        endcase
    end

    //-------------------------------------------------------------------------
    // FSM: outputs and state decodes
    //-------------------------------------------------------------------------
    always_comb begin
        accessible = (state == READY);
        sweep_last = (state == CLEAR) && (sweep_cnt == LAST_IDX);
        oReady     = accessible;
    end

    //-------------------------------------------------------------------------
    // Sweep counter: walks 0..MEM_SIZE-1 while clearing, parked at 0 otherwise
    // so a new sweep always starts from word 0.
    //-------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sweep_cnt <= '0;
        end else if (state == CLEAR) begin
            sweep_cnt <= sweep_last ? '0 : sweep_cnt + IDX_W'(1);
        end else begin
            sweep_cnt <= '0;
        end
    end

    //-------------------------------------------------------------------------
    // Write port arbitration. The sweep owns the array while clearing; in
    // READY a clear request wins over a same-cycle user write, and writes to
    // addresses beyond MEM_SIZE are dropped.
    //-------------------------------------------------------------------------
    always_comb begin
        wr_in_range = ({1'b0, iWriteAddress} < ADDR_LIMIT);
        user_write  = accessible && iWriteEnable && !iClear && wr_in_range;

        mem_we    = 1'b0;
        mem_widx  = sweep_cnt;
        mem_wdata = '0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (user_write) begin
            mem_we    = 1'b1;
            mem_widx  = iWriteAddress[IDX_W-1:0];
            mem_wdata = iDataIn;
        end
    end

    // NOTE: the storage array deliberately has no reset; a reset on every
    // word would turn it into a huge flop bank. The clear sweep zeroes it.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    //-------------------------------------------------------------------------
    // Read ports. Each port picks its word combinationally from the array
    // (or from the write data when bypassing) and registers it, so every
    // output comes straight from a flop.
    //-------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] raddr;
        logic                  rd_in_range;
        logic                  write_hit;
        logic                  rd_take;
        logic [DATA_WIDTH-1:0] rd_word;
        logic [DATA_WIDTH-1:0] rd_data;
        logic                  rd_valid;

        assign raddr = iReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_in_range = ({1'b0, raddr} < ADDR_LIMIT);
            write_hit   = user_write && (raddr == iWriteAddress);
            rd_take     = accessible && iReadEnable[k];

            // Out-of-range addresses read as zero rather than aliasing.
            rd_word = '0;
            if (rd_in_range) begin
                if ((BYPASS != 0) && write_hit) begin
                    rd_word = iDataIn;
                end else begin
                    rd_word = mem[raddr[IDX_W-1:0]];
                end
            end
        end

        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_take;
                if (rd_take) begin
                    rd_data <= rd_word;
                end
            end
        end

        assign oDataOut[k*DATA_WIDTH +: DATA_WIDTH] = rd_data;
        assign oReadValid[k]                        = rd_valid;
    end

endmodule

// File: doc/ram_multi_read_port.md
Name: ram_multi_read_port

Overview:
Parametrised register-file RAM: one synchronous write port and NUM_READ synchronous read ports, each read port with a registered output and a valid flag. It adds two features: a selectable read-during-write mode (old data or write-through bypass), and a hardware clear sequencer that zeroes every word after reset or on request. It sits between the datapath register/operand logic and the execute stage, and is the general operand store for multi-issue reads.

Parameters:
DATA_WIDTH, 16, word width in bits.
ADDR_WIDTH, 8, address width for every port.
MEM_SIZE, 256, number of words; legal addresses are 0..MEM_SIZE-1; must satisfy MEM_SIZE <= 2**ADDR_WIDTH.
NUM_READ, 4, number of read ports (1..8).
BYPASS, 0, read-during-write mode: 0 returns the old word, 1 returns the word being written.

Ports:
Clock  input  1  rising-edge clock for all state.
Reset  input  1  asynchronous, active-low reset; asserted at 0.
iClear  input  1  one-cycle pulse; restarts the clear sweep (honoured only in READY).
iWriteEnable  input  1  write strobe.
iWriteAddress  input  ADDR_WIDTH  write address.
iDataIn  input  DATA_WIDTH  write data.
iReadEnable  input  NUM_READ  per-port read strobe; bit k belongs to port k.
iReadAddress  input  NUM_READ*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
oDataOut  output  NUM_READ*DATA_WIDTH  packed registered read data; same packing as iReadAddress.
oReadValid  output  NUM_READ  per-port flag: oDataOut slice updated this cycle.
oReady  output  1  high when the array is accessible (state READY).

Behaviour:
- Reset assertion (Reset=0), asynchronous:
  - oDataOut=0, oReadValid=0, oReady=0, sweep counter=0, state=CLEAR.
  - The memory array has no reset; it is zeroed by the sweep.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 to Ram[counter], then counter increments.
  - When counter==MEM_SIZE-1 is written, the next state is READY and the counter returns to 0.
  - The sweep takes exactly MEM_SIZE cycles after the first rising edge with Reset=1.
  - oReady rises on the edge that enters READY.
- CLEAR port activity:
  - iWriteEnable, iClear and iReadEnable are ignored.
  - oReadValid=0 and oDataOut holds its value.
- READY, iClear=1: next state is CLEAR, counter=0, oReady drops on the next edge. Any write in the same cycle is dropped (clear wins).
- Write, READY only: if iWriteEnable=1 and iWriteAddress<MEM_SIZE, then Ram[iWriteAddress]<=iDataIn at the edge. Out-of-range writes are discarded silently.
- Read, port k, READY only, latency 1 cycle:
  - iReadEnable[k]=1 at edge N: the oDataOut slice k and oReadValid[k]=1 are visible after edge N.
  - iReadEnable[k]=0: slice k holds its previous value and oReadValid[k]=0.
  - Out-of-range read address returns 0 with oReadValid[k]=1.
- Read-during-write, same address, same edge:
  - BYPASS=0: port returns the pre-write word.
  - BYPASS=1: port returns iDataIn.
  - The comparison is per port; several ports may hit the write address at once and each follows the rule independently.
- Multiple ports reading the same address in one cycle all receive identical data.
- Reset asserted mid-sweep or mid-operation: outputs clear immediately; the sweep restarts from 0 after release. Memory contents before the restart are unspecified until the sweep completes.
- No combinational path from any input to any output.

Test Plan:
- Reset release, MEM_SIZE=256: oReady stays 0 for exactly 256 edges, then rises. A read of addr 0x37 then returns 0x0000 with oReadValid=1 one cycle later.
- Write 0xBEEF to addr 5; next cycle read addr 5 on ports 0..3 simultaneously -> all four slices show 0xBEEF, oReadValid=4'b1111.
- Addr 9 holds 0x1111; write 0x2222 to addr 9 while port 2 reads addr 9 -> BYPASS=0 returns 0x1111, BYPASS=1 returns 0x2222. The following read returns 0x2222 in both modes.
- Port 1 enabled, then iReadEnable[1]=0 for 3 cycles while addr changes -> slice 1 holds its last value, oReadValid[1]=0 throughout.
- MEM_SIZE=200: write 0xAAAA to addr 210, then read addr 210 -> 0x0000; addr 199 is unaffected.
- Pulse iClear after writing 0x1234 to addr 3, with a write to addr 4 in the same cycle -> oReady=0 for 256 cycles, both writes lost, addr 3 and addr 4 read 0x0000. Reset asserted at sweep cycle 100 restarts the full 256-cycle sweep.
